// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU with a registered carry flag, a zero flag,
// iterative shifts, an iterative shift-add multiplier and valid/ready
// handshakes on both sides. Only one operation is in flight at a time.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic             cf_sel_i,
  input  logic [WIDTH-1:0] oprnd_0_i,
  input  logic [WIDTH-1:0] oprnd_1_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] alu_result_o,
  output logic [WIDTH-1:0] alu_result_hi_o,
  output logic             cf_o,
  output logic             zf_o,
  output logic             err_o
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_INV = 4'd5;
  localparam logic [3:0] OP_SHL = 4'd6;
  localparam logic [3:0] OP_SHR = 4'd7;
  localparam logic [3:0] OP_SAR = 4'd8;
  localparam logic [3:0] OP_MUL = 4'd9;

  // Counter is one bit wider than a shift distance so it can hold WIDTH
  // (WIDTH is a power of two, so WIDTH == 1 << SHW).
  localparam logic [SHW:0]       CNT_ONE  = {{SHW{1'b0}}, 1'b1};
  localparam logic [SHW:0]       CNT_W    = {1'b1, {SHW{1'b0}}};
  localparam logic [SHW-1:0]     DIST_0   = {SHW{1'b0}};
  localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MUL   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Zero flag covers both result halves.
  function automatic logic f_is_zero(input logic [WIDTH-1:0] lo,
                                     input logic [WIDTH-1:0] hi);
    f_is_zero = ((lo | hi) == ZERO_W);
  endfunction

  // Registered state and outputs
  state_t             r_state;
  logic               r_ready;
  logic               r_valid;
  logic               r_cf;
  logic               r_zf;
  logic               r_err;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_res_hi;
  logic [WIDTH-1:0]   r_work;    // shift working value, or multiplicand
  logic [3:0]         r_op;
  logic [SHW:0]       r_cnt;
  logic [2*WIDTH-1:0] r_acc;     // {partial product high, remaining multiplier}

  // Combinational datapath
  logic               w_accept;
  logic               w_cin;
  logic               w_is_shift;
  logic [SHW-1:0]     w_dist;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sub;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_cf;
  logic               w_alu_err;
  logic [WIDTH-1:0]   w_shift_next;
  logic               w_shift_out;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  logic               w_fin;
  logic [WIDTH-1:0]   w_fin_lo;
  logic [WIDTH-1:0]   w_fin_hi;
  logic               w_fin_cf;
  logic               w_fin_err;

  assign w_accept   = (r_state == ST_IDLE) & r_ready & valid_i;
  assign w_dist     = oprnd_1_i[SHW-1:0];
  assign w_is_shift = (op_i == OP_SHL) | (op_i == OP_SHR) | (op_i == OP_SAR);
  assign w_cin      = cf_sel_i & r_cf;

  // Single-cycle ALU result and flags for the request presented at the inputs
  always_comb begin
    w_add     = {1'b0, oprnd_0_i} + {1'b0, oprnd_1_i} + {ZERO_W, w_cin};
    w_sub     = {1'b0, oprnd_0_i} - {1'b0, oprnd_1_i} - {ZERO_W, w_cin};
    w_alu_res = ZERO_W;
    w_alu_cf  = r_cf;
    w_alu_err = 1'b0;
    case (op_i)
      OP_ADD: begin
        w_alu_res = w_add[WIDTH-1:0];
        w_alu_cf  = w_add[WIDTH];
      end
      OP_SUB: begin
        // The extra top bit of the wide difference is the borrow.
        w_alu_res = w_sub[WIDTH-1:0];
        w_alu_cf  = w_sub[WIDTH];
      end
      OP_AND: w_alu_res = oprnd_0_i & oprnd_1_i;
      OP_OR:  w_alu_res = oprnd_0_i | oprnd_1_i;
      OP_XOR: w_alu_res = oprnd_0_i ^ oprnd_1_i;
      OP_INV: w_alu_res = ~oprnd_0_i;
      // Zero-distance shifts finish immediately with operand a unchanged.
      OP_SHL, OP_SHR, OP_SAR, OP_MUL: w_alu_res = oprnd_0_i;
      default: begin
        w_alu_res = ZERO_W;
        w_alu_err = 1'b1;
      end
    endcase
  end

  // One-bit shift step applied to the working value while in SHIFT
  always_comb begin
    w_shift_next = r_work;
    w_shift_out  = 1'b0;
    case (r_op)
      OP_SHL: begin
        w_shift_next = {r_work[WIDTH-2:0], 1'b0};
        w_shift_out  = r_work[WIDTH-1];
      end
      OP_SHR: begin
        w_shift_next = {1'b0, r_work[WIDTH-1:1]};
        w_shift_out  = r_work[0];
      end
      OP_SAR: begin
        w_shift_next = {r_work[WIDTH-1], r_work[WIDTH-1:1]};
        w_shift_out  = r_work[0];
      end
      default: begin
        w_shift_next = r_work;
        w_shift_out  = 1'b0;
      end
    endcase
  end

  // One shift-add multiplier iteration: add multiplicand when the current
  // multiplier bit is set, then shift the whole accumulator right by one
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
               + ({(WIDTH+1){r_acc[0]}} & {1'b0, r_work});
    w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  end

  // Decide whether this edge enters DONE, and with which result and flags
  always_comb begin
    w_fin     = 1'b0;
    w_fin_lo  = w_alu_res;
    w_fin_hi  = ZERO_W;
    w_fin_cf  = r_cf;
    w_fin_err = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && (op_i != OP_MUL) && !(w_is_shift && (w_dist != DIST_0))) begin
          w_fin     = 1'b1;
          w_fin_lo  = w_alu_res;
          w_fin_cf  = w_alu_cf;
          w_fin_err = w_alu_err;
        end else begin
          w_fin     = 1'b0;
        end
      end
      ST_SHIFT: begin
        w_fin    = (r_cnt == CNT_ONE);
        w_fin_lo = w_shift_next;
        w_fin_cf = w_shift_out;
      end
      ST_MUL: begin
        w_fin    = (r_cnt == CNT_ONE);
        w_fin_lo = w_mul_next[WIDTH-1:0];
        w_fin_hi = w_mul_next[2*WIDTH-1:WIDTH];
        w_fin_cf = |w_mul_next[2*WIDTH-1:WIDTH];
      end
      default: begin
        w_fin    = 1'b0;
      end
    endcase
  end

  // Control FSM, iteration registers and registered result/flag outputs
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_ready  <= 1'b0;
      r_valid  <= 1'b0;
      r_cf     <= 1'b0;
      r_zf     <= 1'b0;
      r_err    <= 1'b0;
      r_res    <= ZERO_W;
      r_res_hi <= ZERO_W;
      r_work   <= ZERO_W;
      r_op     <= 4'd0;
      r_cnt    <= {(SHW+1){1'b0}};
      r_acc    <= {(2*WIDTH){1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_ready <= 1'b0;
            r_op    <= op_i;
            r_work  <= oprnd_0_i;
            r_acc   <= {ZERO_W, oprnd_1_i};
            if (w_fin) begin
              r_state <= ST_DONE;
            end else if (op_i == OP_MUL) begin
              r_state <= ST_MUL;
              r_cnt   <= CNT_W;
            end else begin
              r_state <= ST_SHIFT;
              r_cnt   <= {1'b0, w_dist};
            end
          end else begin
            // Ready rises on the first edge after reset and stays up in IDLE.
            r_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          r_work <= w_shift_next;
          r_cnt  <= r_cnt - CNT_ONE;
          if (w_fin) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_SHIFT;
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt - CNT_ONE;
          if (w_fin) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_MUL;
          end
        end
        ST_DONE: begin
          // Hold everything until downstream takes the result; valid_i is
          // not looked at here, so nothing is accepted on the retire edge.
          if (ready_i) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_valid <= 1'b0;
          r_ready <= 1'b0;
        end
      endcase

      // Result registers and cf change only on entry to DONE.
      if (w_fin) begin
        r_res    <= w_fin_lo;
        r_res_hi <= w_fin_hi;
        r_cf     <= w_fin_cf;
        r_zf     <= f_is_zero(w_fin_lo, w_fin_hi);
        r_err    <= w_fin_err;
        r_valid  <= 1'b1;
      end
    end
  end

  assign ready_o         = r_ready;
  assign valid_o         = r_valid;
  assign alu_result_o    = r_res;
  assign alu_result_hi_o = r_res_hi;
  assign cf_o            = r_cf;
  assign zf_o            = r_zf;
  assign err_o           = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq (WIDTH=8): directed vectors, randomized
// operations against an arithmetic reference model, backpressure and reset.
module tb_alu_seq;

  localparam int W = 8;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         valid_i;
  logic         ready_o;
  logic [3:0]   op_i;
  logic         cf_sel_i;
  logic [W-1:0] oprnd_0_i;
  logic [W-1:0] oprnd_1_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] alu_result_o;
  logic [W-1:0] alu_result_hi_o;
  logic         cf_o;
  logic         zf_o;
  logic         err_o;

  int   errors = 0;
  int   checks = 0;
  logic m_cf   = 1'b0;   // model's view of the carry flag

  alu_seq #(.WIDTH(W)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .op_i            (op_i),
    .cf_sel_i        (cf_sel_i),
    .oprnd_0_i       (oprnd_0_i),
    .oprnd_1_i       (oprnd_1_i),
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .alu_result_o    (alu_result_o),
    .alu_result_hi_o (alu_result_hi_o),
    .cf_o            (cf_o),
    .zf_o            (zf_o),
    .err_o           (err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       sel;
    logic [7:0] lo;
    logic [7:0] hi;
    logic       cf;
    logic       zf;
    logic       err;
    logic [7:0] lat;
  } vec_t;

  // Reference model: plain integer arithmetic from the operation rules.
  function automatic void model(input logic [3:0] op, input logic [7:0] a,
                                input logic [7:0] b, input logic sel,
                                input logic cf_in, output logic [7:0] lo,
                                output logic [7:0] hi, output logic cf,
                                output logic err, output int lat);
    int ia, ib, d, cin, s, sa, p;
    ia = a; ib = b; d = ib % 8; cin = (sel && cf_in) ? 1 : 0;
    lo = 8'h00; hi = 8'h00; cf = cf_in; err = 1'b0; lat = 1;
    case (op)
      4'd0: begin s = ia + ib + cin; lo = 8'(s); cf = (s > 255); end
      4'd1: begin s = ia - ib - cin; lo = 8'(s); cf = (ia < ib + cin); end
      4'd2: lo = a & b;
      4'd3: lo = a | b;
      4'd4: lo = a ^ b;
      4'd5: lo = ~a;
      4'd6: begin
        lat = 1 + d; lo = a;
        if (d > 0) begin lo = 8'(ia << d); cf = ((ia >> (8 - d)) & 1) == 1; end
      end
      4'd7: begin
        lat = 1 + d; lo = a;
        if (d > 0) begin lo = 8'(ia >> d); cf = ((ia >> (d - 1)) & 1) == 1; end
      end
      4'd8: begin
        lat = 1 + d; lo = a; sa = (ia >= 128) ? ia - 256 : ia;
        if (d > 0) begin lo = 8'(sa >>> d); cf = ((sa >>> (d - 1)) & 1) == 1; end
      end
      4'd9: begin p = ia * ib; lo = 8'(p); hi = 8'(p >> 8); cf = (hi != 8'h00); lat = 1 + W; end
      default: err = 1'b1;
    endcase
  endfunction

  // Drive one request, measure latency, capture outputs, then retire it.
  task automatic exec(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic sel, output logic [7:0] lo, output logic [7:0] hi,
                      output logic cf, output logic zf, output logic err, output int lat);
    int guard = 0;
    while (ready_o !== 1'b1 && guard < 50) begin @(posedge clk_i); #1; guard++; end
    if (guard >= 50) begin
      checks++; errors++;
      $display("FAIL ready_timeout got ready_o=%b expected 1", ready_o);
    end
    op_i = op; oprnd_0_i = a; oprnd_1_i = b; cf_sel_i = sel; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 1;
    while (valid_o !== 1'b1 && lat < 40) begin @(posedge clk_i); #1; lat++; end
    lo = alu_result_o; hi = alu_result_hi_o; cf = cf_o; zf = zf_o; err = err_o;
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; op_i = 4'd0;
    cf_sel_i = 1'b0; oprnd_0_i = 8'h00; oprnd_1_i = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({ready_o, valid_o, cf_o, zf_o, err_o, alu_result_o, alu_result_hi_o} !== 21'd0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b vld=%b cf=%b zf=%b err=%b lo=%h hi=%h expected all 0",
               ready_o, valid_o, cf_o, zf_o, err_o, alu_result_o, alu_result_hi_o);
    end
    rst_n_i = 1'b1;
    @(posedge clk_i); #1;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got ready_o=%b valid_o=%b expected 1/0", ready_o, valid_o);
    end
    m_cf = 1'b0;
  endtask

  task automatic test_directed();
    vec_t dir [17];
    logic [7:0] lo, hi;
    logic cf, zf, err;
    int lat;
    //            op     a      b      sel   lo     hi     cf    zf    err   lat
    dir[0]  = '{4'd0,  8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
    dir[1]  = '{4'd0,  8'h01, 8'h01, 1'b1, 8'h03, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1};
    dir[2]  = '{4'd1,  8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
    dir[3]  = '{4'd1,  8'h07, 8'h07, 1'b1, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
    dir[4]  = '{4'd4,  8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1};
    dir[5]  = '{4'd6,  8'h81, 8'h03, 1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 8'd4};
    dir[6]  = '{4'd7,  8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2};
    dir[7]  = '{4'd6,  8'h55, 8'h08, 1'b0, 8'h55, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
    dir[8]  = '{4'd8,  8'h80, 8'h0A, 1'b0, 8'hE0, 8'h00, 1'b0, 1'b0, 1'b0, 8'd3};
    dir[9]  = '{4'd9,  8'h0F, 8'h11, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'd9};
    dir[10] = '{4'd9,  8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 1'b1, 1'b0, 1'b0, 8'd9};
    dir[11] = '{4'd12, 8'h33, 8'h44, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'd1};
    dir[12] = '{4'd2,  8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 1'b0, 8'd1};
    dir[13] = '{4'd5,  8'hFF, 8'h12, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1};
    dir[14] = '{4'd8,  8'h81, 8'h01, 1'b0, 8'hC0, 8'h00, 1'b1, 1'b0, 1'b0, 8'd2};
    dir[15] = '{4'd0,  8'hFE, 8'h01, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1};
    dir[16] = '{4'd1,  8'h00, 8'hFF, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'd1};
    for (int i = 0; i < 17; i++) begin
      exec(dir[i].op, dir[i].a, dir[i].b, dir[i].sel, lo, hi, cf, zf, err, lat);
      checks++; if (lo !== dir[i].lo) begin errors++; $display("FAIL dir%0d_lo got %h expected %h", i, lo, dir[i].lo); end
      checks++; if (hi !== dir[i].hi) begin errors++; $display("FAIL dir%0d_hi got %h expected %h", i, hi, dir[i].hi); end
      checks++; if (cf !== dir[i].cf) begin errors++; $display("FAIL dir%0d_cf got %b expected %b", i, cf, dir[i].cf); end
      checks++; if (zf !== dir[i].zf) begin errors++; $display("FAIL dir%0d_zf got %b expected %b", i, zf, dir[i].zf); end
      checks++; if (err !== dir[i].err) begin errors++; $display("FAIL dir%0d_err got %b expected %b", i, err, dir[i].err); end
      checks++; if (lat != int'(dir[i].lat)) begin errors++; $display("FAIL dir%0d_lat got %0d expected %0d", i, lat, dir[i].lat); end
      m_cf = dir[i].cf;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] elo, ehi;
    logic ecf, eerr;
    int elat, guard;
    model(4'd0, 8'h12, 8'h34, 1'b0, m_cf, elo, ehi, ecf, eerr, elat);
    op_i = 4'd0; oprnd_0_i = 8'h12; oprnd_1_i = 8'h34; cf_sel_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    guard = 0;
    while (valid_o !== 1'b1 && guard < 20) begin @(posedge clk_i); #1; guard++; end
    for (int c = 0; c < 5; c++) begin
      valid_i = ~valid_i; op_i = 4'd9; oprnd_0_i = 8'(c + 3); oprnd_1_i = 8'h77;
      @(posedge clk_i); #1;
      checks++;
      if (valid_o !== 1'b1 || ready_o !== 1'b0 || alu_result_o !== elo || cf_o !== ecf) begin
        errors++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b lo=%h cf=%b expected 1/0/%h/%b",
                 c, valid_o, ready_o, alu_result_o, cf_o, elo, ecf);
      end
    end
    valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0; ready_i = 1'b0;
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_retire got ready_o=%b valid_o=%b expected 1/0", ready_o, valid_o);
    end
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL bp_no_capture got valid_o=%b ready_o=%b expected 0/1", valid_o, ready_o);
    end
    m_cf = ecf;
  endtask

  task automatic test_random();
    logic [7:0] a, b, lo, hi, elo, ehi;
    logic [3:0] op;
    logic sel, cf, zf, err, ecf, eerr, ezf;
    int lat, elat;
    for (int n = 0; n < 40; n++) begin
      op = 4'($urandom_range(0, 15));
      if (n % 3 == 0) op = 4'($urandom_range(6, 9));
      a = 8'($urandom); b = 8'($urandom); sel = 1'($urandom);
      model(op, a, b, sel, m_cf, elo, ehi, ecf, eerr, elat);
      ezf = (elo == 8'h00) && (ehi == 8'h00);
      exec(op, a, b, sel, lo, hi, cf, zf, err, lat);
      checks++;
      if ({lo, hi, cf, zf, err} !== {elo, ehi, ecf, ezf, eerr} || lat != elat) begin
        errors++;
        $display("FAIL rnd%0d op=%0d a=%h b=%h sel=%b got lo=%h hi=%h cf=%b zf=%b err=%b L=%0d expected lo=%h hi=%h cf=%b zf=%b err=%b L=%0d",
                 n, op, a, b, sel, lo, hi, cf, zf, err, lat, elo, ehi, ecf, ezf, eerr, elat);
      end
      m_cf = ecf;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] lo, hi;
    logic cf, zf, err;
    int lat;
    exec(4'd0, 8'hFF, 8'h01, 1'b0, lo, hi, cf, zf, err, lat);
    checks++;
    if (cf !== 1'b1) begin errors++; $display("FAIL rm_setup_cf got %b expected 1", cf); end
    op_i = 4'd9; oprnd_0_i = 8'hFF; oprnd_1_i = 8'hFF; cf_sel_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({ready_o, valid_o, cf_o, zf_o, err_o, alu_result_o, alu_result_hi_o} !== 21'd0) begin
      errors++;
      $display("FAIL rm_abort got rdy=%b vld=%b cf=%b zf=%b err=%b lo=%h hi=%h expected all 0",
               ready_o, valid_o, cf_o, zf_o, err_o, alu_result_o, alu_result_hi_o);
    end
    @(posedge clk_i); #1;
    rst_n_i = 1'b1;
    m_cf = 1'b0;
    @(posedge clk_i); #1;
    exec(4'd0, 8'h02, 8'h03, 1'b0, lo, hi, cf, zf, err, lat);
    checks++;
    if (lo !== 8'h05 || cf !== 1'b0 || lat != 1) begin
      errors++;
      $display("FAIL rm_after got lo=%h cf=%b L=%0d expected 05/0/1", lo, cf, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
